// File: rtl/tage_update_queue.sv
// tage_update_queue
// Update-side checkpoint FIFO for the TAGE predictor. Every issued prediction
// (direction, provider bank/pointer, pre-shift GHR, PC) is stored in program
// order. Each backend resolution is paired with the oldest entry.
// - When the PC and direction both match, the queue emits a training update
//   and pops the entry.
// - On a direction mismatch, the queue emits the training update with a GHR
//   restore, then clears the queue.
// - On a PC mismatch, the queue raises SyncErr and clears the queue.
//
// Ports
//   Clk, Rest                       clock, async active-high reset
//   PredAble/Taken/Bank/Ptr/GHR/Pc  enqueue side (from predictor)
//   Full, Empty, Count              registered occupancy status
//   ResAble/ResTaken/ResPc          resolution of oldest branch
//   Flush                           pipeline flush, clears everything
//   UpDate*/UpdateGHR/UpdatePc      registered training port, 1-cycle valid
//   GhrRestore, Mispredict, SyncErr single-cycle pulses with the update
//   OverflowErr                     sticky: prediction dropped while full
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif

module tage_update_queue #(
  parameter int DEPTH       = 8,
  parameter int PTRW        = 3,
  parameter int TAGEBANK    = 6,
  parameter int TAGEBANWIDE = 3,
  parameter int GHRWIDE     = 72
) (
  input  logic                   Clk,
  input  logic                   Rest,
  input  logic                   PredAble,
  input  logic                   PredTaken,
  input  logic [TAGEBANK-1:0]    PredBank,
  input  logic [TAGEBANWIDE-1:0] PredPtr,
  input  logic [GHRWIDE-1:0]     PredGHR,
  input  logic [`InstAddrBus]    PredPc,
  output logic                   Full,
  output logic                   Empty,
  output logic [PTRW:0]          Count,
  input  logic                   ResAble,
  input  logic                   ResTaken,
  input  logic [`InstAddrBus]    ResPc,
  input  logic                   Flush,
  output logic                   UpDateAble,
  output logic                   UpDatePredict,
  output logic [TAGEBANK-1:0]    UpDateSelectB,
  output logic [TAGEBANWIDE-1:0] UpDateSelectP,
  output logic [GHRWIDE-1:0]     UpdateGHR,
  output logic [`InstAddrBus]    UpdatePc,
  output logic                   GhrRestore,
  output logic                   Mispredict,
  output logic                   SyncErr,
  output logic                   OverflowErr
);

  typedef struct packed {
    logic                   taken;
    logic [TAGEBANK-1:0]    bank;
    logic [TAGEBANWIDE-1:0] ptr;
    logic [GHRWIDE-1:0]     ghr;
    logic [`InstAddrBus]    pc;
  } ent_t;

  localparam logic [PTRW:0] FULLCNT = DEPTH[PTRW:0];

  ent_t            mem [DEPTH];
  ent_t            hd;
  logic [PTRW-1:0] head, tail;
  logic [PTRW:0]   cnt;

  logic res_v, pc_ok, dir_ok, pop, clr, enq, ovf;

  assign hd    = mem[head];
  assign Count = cnt;
  assign Full  = (cnt == FULLCNT);
  assign Empty = (cnt == '0);

  always_comb begin
    // A resolve only counts when something is queued and no flush overrides it.
    res_v  = ResAble && (cnt != '0) && !Flush;
    pc_ok  = (ResPc == hd.pc);
    dir_ok = (ResTaken == hd.taken);
    pop    = res_v && pc_ok && dir_ok;
    // Mispredict and PC desync both discard every checkpoint, same as a flush.
    clr    = Flush || (res_v && !(pc_ok && dir_ok));
    // Full is judged after the pop, so enqueue + correct resolve always fits.
    enq    = PredAble && !clr && (!Full || pop);
    ovf    = PredAble && !clr && Full && !pop;
  end

  always_ff @(posedge Clk) begin
    if (enq) mem[tail] <= '{PredTaken, PredBank, PredPtr, PredGHR, PredPc};
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      head        <= '0;
      tail        <= '0;
      cnt         <= '0;
      OverflowErr <= 1'b0;
    end else begin
      if (ovf) OverflowErr <= 1'b1;
      if (clr) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (pop) head <= head + PTRW'(1);
        if (enq) tail <= tail + PTRW'(1);
        case ({enq, pop})
          2'b10:   cnt <= cnt + (PTRW+1)'(1);
          2'b01:   cnt <= cnt - (PTRW+1)'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Training port: all fields forced to zero unless an update fires.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      UpDateAble    <= 1'b0;
      UpDatePredict <= 1'b0;
      UpDateSelectB <= '0;
      UpDateSelectP <= '0;
      UpdateGHR     <= '0;
      UpdatePc      <= '0;
      GhrRestore    <= 1'b0;
      Mispredict    <= 1'b0;
      SyncErr       <= 1'b0;
    end else begin
      UpDateAble    <= res_v && pc_ok;
      UpDatePredict <= res_v && pc_ok && ResTaken;
      UpDateSelectB <= (res_v && pc_ok) ? hd.bank : '0;
      UpDateSelectP <= (res_v && pc_ok) ? hd.ptr  : '0;
      UpdateGHR     <= (res_v && pc_ok) ? {hd.ghr[GHRWIDE-2:0], ResTaken} : '0;
      UpdatePc      <= (res_v && pc_ok) ? hd.pc   : '0;
      GhrRestore    <= res_v && pc_ok && !dir_ok;
      Mispredict    <= res_v && pc_ok && !dir_ok;
      SyncErr       <= res_v && !pc_ok;
    end
  end

endmodule

// File: tb/tb_tage_update_queue.sv
// Directed bench for tage_update_queue: hand-computed expectations checked
// with immediate assertions after each clock edge.
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif

module tb_tage_update_queue;
  logic        Clk = 0, Rest = 1;
  logic        PredAble = 0, PredTaken = 0;
  logic [5:0]  PredBank = '0;
  logic [2:0]  PredPtr = '0;
  logic [71:0] PredGHR = '0;
  logic [31:0] PredPc = '0;
  logic        Full, Empty;
  logic [3:0]  Count;
  logic        ResAble = 0, ResTaken = 0, Flush = 0;
  logic [31:0] ResPc = '0;
  logic        UpDateAble, UpDatePredict;
  logic [5:0]  UpDateSelectB;
  logic [2:0]  UpDateSelectP;
  logic [71:0] UpdateGHR;
  logic [31:0] UpdatePc;
  logic        GhrRestore, Mispredict, SyncErr, OverflowErr;

  int ncmp = 0, nerr = 0;

  tage_update_queue dut (
    .Clk(Clk), .Rest(Rest),
    .PredAble(PredAble), .PredTaken(PredTaken), .PredBank(PredBank),
    .PredPtr(PredPtr), .PredGHR(PredGHR), .PredPc(PredPc),
    .Full(Full), .Empty(Empty), .Count(Count),
    .ResAble(ResAble), .ResTaken(ResTaken), .ResPc(ResPc), .Flush(Flush),
    .UpDateAble(UpDateAble), .UpDatePredict(UpDatePredict),
    .UpDateSelectB(UpDateSelectB), .UpDateSelectP(UpDateSelectP),
    .UpdateGHR(UpdateGHR), .UpdatePc(UpdatePc),
    .GhrRestore(GhrRestore), .Mispredict(Mispredict), .SyncErr(SyncErr),
    .OverflowErr(OverflowErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs applied before this call are sampled there.
  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic idle();
    PredAble = 0; ResAble = 0; Flush = 0;
  endtask

  task automatic pred(input logic [31:0] pc, input logic t, input logic [71:0] g,
                      input logic [5:0] b, input logic [2:0] p);
    PredAble = 1; PredPc = pc; PredTaken = t; PredGHR = g; PredBank = b; PredPtr = p;
  endtask

  task automatic res(input logic [31:0] pc, input logic t);
    ResAble = 1; ResPc = pc; ResTaken = t;
  endtask

  initial begin
    // ---- reset state
    #2;
    chk("rst_empty", Empty, 1); chk("rst_full", Full, 0); chk("rst_count", Count, 0);
    chk("rst_upd", UpDateAble, 0); chk("rst_ovf", OverflowErr, 0);
    step(); Rest = 0; step();

    // ---- three in-order correct resolves
    pred(32'h100, 1, 72'h5, 6'b000001, 3'd1); step();
    pred(32'h104, 0, 72'h7, 6'b000010, 3'd2); step();
    pred(32'h108, 1, 72'h9, 6'b000100, 3'd3); step();
    idle(); chk("t1_count3", Count, 3);
    res(32'h100, 1); step();
    chk("t1a_upd", UpDateAble, 1); chk("t1a_pc", UpdatePc, 32'h100);
    chk("t1a_pred", UpDatePredict, 1); chk("t1a_ghr", UpdateGHR, 72'hB);
    chk("t1a_selb", UpDateSelectB, 6'b000001); chk("t1a_selp", UpDateSelectP, 1);
    chk("t1a_rest", GhrRestore, 0); chk("t1a_count", Count, 2);
    res(32'h104, 0); step();
    chk("t1b_upd", UpDateAble, 1); chk("t1b_pc", UpdatePc, 32'h104);
    chk("t1b_ghr", UpdateGHR, 72'hE); chk("t1b_rest", GhrRestore, 0);
    res(32'h108, 1); step();
    chk("t1c_upd", UpDateAble, 1); chk("t1c_pc", UpdatePc, 32'h108);
    chk("t1c_selp", UpDateSelectP, 3); chk("t1c_count", Count, 0);
    idle(); step();
    chk("t1_idle_upd", UpDateAble, 0); chk("t1_empty", Empty, 1);

    // ---- mispredict flushes younger entries
    pred(32'h200, 1, 72'h1, 6'b001000, 3'd4); step();
    pred(32'h204, 0, 72'h3, 6'b000001, 3'd0); step();
    pred(32'h208, 0, 72'h6, 6'b000001, 3'd0); step();
    idle(); res(32'h200, 0); step();
    chk("t2_mis", Mispredict, 1); chk("t2_rest", GhrRestore, 1);
    chk("t2_ghr", UpdateGHR, 72'h2); chk("t2_upd", UpDateAble, 1);
    chk("t2_pred", UpDatePredict, 0); chk("t2_count", Count, 0);
    idle(); step();
    chk("t2_mis_pulse", Mispredict, 0); chk("t2_rest_pulse", GhrRestore, 0);

    // ---- fill, overflow, enqueue+pop while full
    for (int i = 0; i < 8; i++) begin
      pred(32'h300 + 4*i, i[0], 72'(i), 6'b000001, 3'(i)); step();
    end
    idle(); chk("t3_full", Full, 1); chk("t3_count8", Count, 8);
    pred(32'h999, 1, 72'h0, 6'b0, 3'd0); step();
    idle(); chk("t3_ovf", OverflowErr, 1); chk("t3_count_ovf", Count, 8);
    pred(32'h400, 1, 72'h0, 6'b100000, 3'd7); res(32'h300, 0); step();
    idle(); chk("t3_both_upd", UpDateAble, 1); chk("t3_both_count", Count, 8);
    for (int i = 1; i < 8; i++) begin
      res(32'h300 + 4*i, i[0]); step();
      chk("t3_drain_pc", UpdatePc, 32'h300 + 4*i);
    end
    res(32'h400, 1); step();
    chk("t3_tail_pc", UpdatePc, 32'h400); chk("t3_tail_selb", UpDateSelectB, 6'b100000);
    chk("t3_drained", Count, 0);

    // ---- resolve at empty ignored; then PC desync
    pred(32'h500, 1, 72'h0, 6'b1, 3'd0); res(32'h500, 1); step();
    idle(); chk("t4_noupd", UpDateAble, 0); chk("t4_count1", Count, 1);
    res(32'h504, 1); step();
    idle(); chk("t4_sync", SyncErr, 1); chk("t4_sync_upd", UpDateAble, 0);
    chk("t4_sync_count", Count, 0);
    step(); chk("t4_sync_pulse", SyncErr, 0);

    // ---- flush overrides everything
    for (int i = 0; i < 5; i++) begin
      pred(32'h600 + 4*i, 0, 72'h0, 6'b1, 3'd0); step();
    end
    idle(); chk("t5_count5", Count, 5);
    Flush = 1; pred(32'h700, 0, 72'h0, 6'b1, 3'd0); res(32'h600, 0); step();
    idle(); chk("t5_flush_count", Count, 0); chk("t5_flush_upd", UpDateAble, 0);
    chk("t5_ovf_sticky", OverflowErr, 1);

    // ---- async reset mid-stream
    pred(32'h700, 0, 72'h0, 6'b1, 3'd0); step();
    pred(32'h704, 0, 72'h0, 6'b1, 3'd0); step();
    idle(); res(32'h700, 0); step();
    idle(); chk("t5_pre_upd", UpDateAble, 1);
    Rest = 1; #1;
    chk("t5_arst_upd", UpDateAble, 0); chk("t5_arst_count", Count, 0);
    chk("t5_arst_ovf", OverflowErr, 0); chk("t5_arst_pc", UpdatePc, 0);
    step(); Rest = 0; step();

    // ---- wrap-around: enqueue i, resolve i-1 in the same cycle
    for (int i = 0; i <= 20; i++) begin
      idle();
      if (i < 20) pred(32'h1000 + 4*i, (i % 3) == 0, 72'(i), 6'b1, 3'(i));
      if (i > 0)  res(32'h1000 + 4*(i-1), ((i-1) % 3) == 0);
      step();
      if (i > 0) begin
        chk("t6_upd", UpDateAble, 1);
        chk("t6_pc", UpdatePc, 32'h1000 + 4*(i-1));
      end
    end
    idle(); chk("t6_count", Count, 0); chk("t6_mis", Mispredict, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
